// File: rtl/nx_mc_sync_fifo.sv
// nx_mc_sync_fifo: single-clock multi-channel FIFO, NUM_CH logical queues in one partitioned store
module nx_mc_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int NUM_CH = 4,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [CHW-1:0]       wch,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 ren,
  input  logic [CHW-1:0]       rch,
  output logic [WIDTH-1:0]     rdata,
  input  logic [NUM_CH-1:0]    flush,
  input  logic                 clr_err,
  output logic [NUM_CH-1:0]    empty,
  output logic [NUM_CH-1:0]    full,
  output logic [NUM_CH-1:0]    almost_full,
  output logic [NUM_CH-1:0]    almost_empty,
  output logic [NUM_CH*CW-1:0] used_slots,
  output logic [NUM_CH-1:0]    overflow,
  output logic [NUM_CH-1:0]    underflow,
  output logic [NUM_CH-1:0]    ovf_sticky,
  output logic [NUM_CH-1:0]    udf_sticky
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CHW:0] NCH = (CHW + 1)'(NUM_CH);
  logic [WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0] wptr [NUM_CH];
  logic [PW-1:0] rptr [NUM_CH];
  logic [CW-1:0] count [NUM_CH];
  logic [NUM_CH-1:0] wsel, rsel, pop, wacc, ovf, udf;
  logic wv, rv;
  assign wv = {1'b0, wch} < NCH;
  assign rv = {1'b0, rch} < NCH;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // flush masks any request on its channel, so it can never raise an error
  always_comb begin
    wsel = '0;
    rsel = '0;
    pop = '0;
    wacc = '0;
    ovf = '0;
    udf = '0;
    empty = '0;
    full = '0;
    almost_full = '0;
    almost_empty = '0;
    used_slots = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wsel[c] = wen && wv && wch == CHW'(c) && !flush[c];
      rsel[c] = ren && rv && rch == CHW'(c) && !flush[c];
      empty[c] = count[c] == '0;
      full[c] = count[c] == CW'(DEPTH);
      almost_full[c] = count[c] >= CW'(AFULL_THRESH);
      almost_empty[c] = count[c] <= CW'(AEMPTY_THRESH);
      pop[c] = rsel[c] && !empty[c];
      wacc[c] = wsel[c] && (!full[c] || pop[c]);
      ovf[c] = wsel[c] && !wacc[c];
      udf[c] = rsel[c] && empty[c];
      used_slots[c*CW +: CW] = count[c];
    end
  end
  assign rdata = (rv && !empty[rch]) ? mem[rch][rptr[rch]] : '0;
  always_ff @(posedge clk)
    for (int c = 0; c < NUM_CH; c++)
      if (wacc[c] && !rst) mem[c][wptr[c]] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '{default: '0};
      rptr <= '{default: '0};
      count <= '{default: '0};
      overflow <= '0;
      underflow <= '0;
      ovf_sticky <= '0;
      udf_sticky <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (flush[c]) begin
          wptr[c] <= '0;
          rptr[c] <= '0;
          count[c] <= '0;
        end else begin
          if (wacc[c]) wptr[c] <= inc(wptr[c]);
          if (pop[c]) rptr[c] <= inc(rptr[c]);
          if (wacc[c] != pop[c]) count[c] <= wacc[c] ? count[c] + 1'b1 : count[c] - 1'b1;
        end
      overflow <= ovf;
      underflow <= udf;
      ovf_sticky <= (clr_err ? '0 : ovf_sticky) | ovf;
      udf_sticky <= (clr_err ? '0 : udf_sticky) | udf;
    end
  always_ff @(posedge clk)
    if (!rst) assert (!(wen && !wv) && !(ren && !rv));
endmodule

// File: tb/tb_nx_mc_sync_fifo.sv
// tb_nx_mc_sync_fifo: table vectors plus per-channel queue scoreboard for nx_mc_sync_fifo
module tb_nx_mc_sync_fifo;
  logic clk = 0, rst = 1, wen = 0, ren = 0, clr_err = 0;
  logic [1:0] wch = 0, rch = 0;
  logic [15:0] wdata = 0, rdata;
  logic [3:0] flush = 0, empty, full, almost_full, almost_empty, overflow, underflow, ovf_sticky, udf_sticky;
  logic [11:0] used_slots;
  int checks = 0, errors = 0;
  logic [15:0] qs [4][$];
  logic [3:0] ovf_s = 0, udf_s = 0, exp_ovf = 0, exp_udf = 0;
  typedef struct {
    logic w; logic [1:0] wc; logic [15:0] wd; logic r; logic [1:0] rc; logic [3:0] fl; logic ce;
    logic [1:0] cc; logic [2:0] eu; logic [3:0] eo; logic [3:0] eud;
  } vec_t;
  vec_t tbl[$];

  nx_mc_sync_fifo #(.WIDTH(16), .DEPTH(6), .NUM_CH(4), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut (
    .clk(clk), .rst(rst), .wen(wen), .wch(wch), .wdata(wdata), .ren(ren), .rch(rch), .rdata(rdata),
    .flush(flush), .clr_err(clr_err), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .used_slots(used_slots), .overflow(overflow), .underflow(underflow),
    .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status();
    logic [3:0] e, f, af, ae;
    logic [11:0] u;
    logic [15:0] hd;
    for (int c = 0; c < 4; c++) begin
      int n = qs[c].size();
      e[c] = n == 0;
      f[c] = n == 6;
      af[c] = n >= 4;
      ae[c] = n <= 1;
      u[c*3 +: 3] = 3'(n);
    end
    hd = (qs[rch].size() > 0) ? qs[rch][0] : 16'h0;
    chk("empty", empty, e);
    chk("full", full, f);
    chk("almost_full", almost_full, af);
    chk("almost_empty", almost_empty, ae);
    chk("used_slots", used_slots, u);
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_udf);
    chk("ovf_sticky", ovf_sticky, ovf_s);
    chk("udf_sticky", udf_sticky, udf_s);
    chk("rdata_head", rdata, hd);
  endtask

  task automatic step(input logic w, input logic [1:0] wc, input logic [15:0] wd, input logic r,
                      input logic [1:0] rc, input logic [3:0] fl, input logic ce);
    logic pop, acc;
    logic [3:0] o, u;
    wen = w; wch = wc; wdata = wd; ren = r; rch = rc; flush = fl; clr_err = ce;
    #1;
    o = '0;
    u = '0;
    pop = r && !fl[rc] && qs[rc].size() > 0;
    if (r && !fl[rc] && qs[rc].size() == 0) u[rc] = 1'b1;
    if (pop) chk("rdata_pop", rdata, qs[rc][0]);
    acc = w && !fl[wc] && (qs[wc].size() < 6 || (pop && rc == wc));
    if (w && !fl[wc] && !acc) o[wc] = 1'b1;
    if (pop) void'(qs[rc].pop_front());
    if (acc) qs[wc].push_back(wd);
    for (int c = 0; c < 4; c++) if (fl[c]) qs[c].delete();
    ovf_s = (ce ? 4'h0 : ovf_s) | o;
    udf_s = (ce ? 4'h0 : udf_s) | u;
    exp_ovf = o;
    exp_udf = u;
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic do_reset();
    rst = 1; wen = 1; wch = 0; wdata = 16'hDEAD; ren = 1; rch = 0; flush = 0; clr_err = 0;
    @(posedge clk);
    #1;
    rst = 0; wen = 0; ren = 0;
    for (int c = 0; c < 4; c++) qs[c].delete();
    ovf_s = 0; udf_s = 0; exp_ovf = 0; exp_udf = 0;
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 4'h0);
    chk("rst_almost_empty", almost_empty, 4'hF);
    chk("rst_almost_full", almost_full, 4'h0);
    chk("rst_used", used_slots, 12'h0);
    chk("rst_pulses", {overflow, underflow}, 8'h0);
    chk("rst_sticky", {ovf_sticky, udf_sticky}, 8'h0);
    chk("rst_rdata", rdata, 16'h0);
  endtask

  task automatic add(input logic w, input logic [1:0] wc, input logic [15:0] wd, input logic r,
                     input logic [1:0] rc, input logic [3:0] fl, input logic ce,
                     input logic [1:0] cc, input logic [2:0] eu, input logic [3:0] eo, input logic [3:0] eud);
    vec_t v;
    v.w = w; v.wc = wc; v.wd = wd; v.r = r; v.rc = rc; v.fl = fl; v.ce = ce;
    v.cc = cc; v.eu = eu; v.eo = eo; v.eud = eud;
    tbl.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) add(1'b1, 2'd2, 16'(16'hA0 + i), 1'b0, 2'd2, 4'h0, 1'b0, 2'd2, 3'(i + 1), 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) add(1'b0, 2'd2, 16'h0, 1'b1, 2'd2, 4'h0, 1'b0, 2'd2, 3'(3 - i), 4'h0, 4'h0);
    add(1'b0, 2'd2, 16'h0, 1'b1, 2'd2, 4'h0, 1'b0, 2'd2, 3'd0, 4'h0, 4'b0100);
    for (int i = 0; i < 6; i++) add(1'b1, 2'd0, 16'(16'h10 + i), 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 3'(i + 1), 4'h0, 4'h0);
    add(1'b1, 2'd0, 16'h16, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 3'd6, 4'b0001, 4'h0);
    add(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 3'd6, 4'h0, 4'h0);
    add(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 3'd6, 4'h0, 4'h0);
    add(1'b1, 2'd0, 16'h17, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 3'd6, 4'b0001, 4'h0);
    add(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 3'd6, 4'h0, 4'h0);
    add(1'b1, 2'd3, 16'h55, 1'b1, 2'd3, 4'h0, 1'b0, 2'd3, 3'd1, 4'h0, 4'b1000);
    add(1'b0, 2'd3, 16'h0, 1'b0, 2'd3, 4'h0, 1'b0, 2'd3, 3'd1, 4'h0, 4'h0);
    add(1'b1, 2'd3, 16'h66, 1'b0, 2'd3, 4'b1000, 1'b0, 2'd3, 3'd0, 4'h0, 4'h0);
    add(1'b1, 2'd0, 16'h18, 1'b1, 2'd0, 4'h0, 1'b0, 2'd0, 3'd6, 4'h0, 4'h0);
    add(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 4'b0001, 1'b0, 2'd0, 3'd0, 4'h0, 4'h0);

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].wc, tbl[i].wd, tbl[i].r, tbl[i].rc, tbl[i].fl, tbl[i].ce);
      chk($sformatf("row%0d_used", i), used_slots[tbl[i].cc*3 +: 3], tbl[i].eu);
      chk($sformatf("row%0d_overflow", i), overflow, tbl[i].eo);
      chk($sformatf("row%0d_underflow", i), underflow, tbl[i].eud);
    end

    for (int i = 0; i < 6; i++) step(1'b1, 2'd1, 16'(16'h100 + i), 1'b0, 2'd1, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'd1, 16'(16'h200 + i), 1'b1, 2'd1, 4'h0, 1'b0);
    chk("ch1_wrap_used", used_slots[5:3], 3'd6);
    chk("ch1_wrap_no_ovf", ovf_sticky[1], 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd1, 16'h0, 1'b1, 2'd1, 4'h0, 1'b0);

    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 2) != 0), 2'($urandom), 16'($urandom), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0, $urandom_range(0, 7) == 0);

    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 16'(16'h300 + i), 1'b0, 2'd0, 4'h0, 1'b0);
    step(1'b1, 2'd1, 16'h311, 1'b0, 2'd0, 4'h0, 1'b0);
    step(1'b1, 2'd0, 16'h0, 1'b1, 2'd3, 4'h0, 1'b0);
    do_reset();
    step(1'b1, 2'd1, 16'hBEEF, 1'b0, 2'd1, 4'h0, 1'b0);
    chk("post_rst_rdata", rdata, 16'hBEEF);
    step(1'b0, 2'd1, 16'h0, 1'b1, 2'd1, 4'h0, 1'b0);
    chk("post_rst_used", used_slots[5:3], 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nx_mc_sync_fifo.md
Name: nx_mc_sync_fifo

Overview:
- Single-clock, multi-channel FIFO. NUM_CH independent logical queues share one partitioned storage array, with one write port and one read port, each carrying a channel select.
- Generalises the single-queue FIFO with:
  - channel count
  - non-power-of-2 depth
  - per-channel flush
  - almost-full/almost-empty thresholds
  - sticky error capture
- Used in front of engines that multiplex several streams, such as per-queue command or descriptor buffering.

Parameters:
- WIDTH, 64, data bits per entry.
- DEPTH, 16, entries per channel; any value ≥2, not restricted to powers of 2.
- NUM_CH, 4, number of logical channels; ≥1.
- AFULL_THRESH, DEPTH-2, almost_full asserts when used ≥ this value.
- AEMPTY_THRESH, 1, almost_empty asserts when used ≤ this value.
- CHW, $clog2(NUM_CH) (minimum 1), channel-select width.
- CW, $clog2(DEPTH+1), occupancy count width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  write request.
- wch  in  CHW  write channel.
- wdata  in  WIDTH  write data.
- ren  in  1  read (pop) request.
- rch  in  CHW  read channel.
- rdata  out  WIDTH  head entry of channel rch; combinational.
- flush  in  NUM_CH  per-channel flush.
- clr_err  in  1  clears the sticky error vectors.
- empty  out  NUM_CH  per-channel empty.
- full  out  NUM_CH  per-channel full.
- almost_full  out  NUM_CH  per-channel, used ≥ AFULL_THRESH.
- almost_empty  out  NUM_CH  per-channel, used ≤ AEMPTY_THRESH.
- used_slots  out  NUM_CH*CW  packed per-channel occupancy; channel c occupies bits [c*CW +: CW].
- overflow  out  NUM_CH  one-cycle pulse, registered.
- underflow  out  NUM_CH  one-cycle pulse, registered.
- ovf_sticky  out  NUM_CH  sticky overflow.
- udf_sticky  out  NUM_CH  sticky underflow.

Behaviour:
- State per channel: wptr and rptr (each $clog2(DEPTH) bits) and count (CW bits). Storage is NUM_CH*DEPTH entries and is not reset.
- Pointer increment: wraps from DEPTH-1 to 0 by explicit compare, not by natural binary overflow.
- Status outputs:
  - empty[c] = (count==0); full[c] = (count==DEPTH).
  - almost_full, almost_empty and used_slots decode combinationally from the count registers, so they reflect an operation from the cycle after it.
- Write accepted when wen && (!full[wch] || pop on wch this cycle).
  - Entry stored at wptr[wch] at the clock edge; wptr increments.
- Pop when ren && !empty[rch]; rptr increments.
- rdata:
  - Equals mem[rch][rptr[rch]] combinationally.
  - Forced to 0 when empty[rch].
  - No write-to-read bypass: a write into an empty channel is visible on rdata the next cycle.
- Count update per channel: +1 for an accepted write only, -1 for a pop only, unchanged for both or neither. wch==rch with both active is legal at any occupancy, including full and empty.
  - Empty channel with wen+ren: the pop is an underflow and the write is accepted; count ends at 1.
- Rejected write (wen, full[wch], no same-channel pop):
  - No state change.
  - overflow[wch]=1 for exactly the next cycle.
  - ovf_sticky[wch] sets.
- Pop on empty: no state change; underflow[rch] pulses next cycle; udf_sticky[rch] sets.
- flush[c]:
  - wptr, rptr and count of channel c go to 0 at the edge.
  - Overrides any wen/ren targeting c in the same cycle; those requests are dropped with no overflow/underflow flagged.
  - Other channels are unaffected.
- Sticky errors:
  - clr_err clears all sticky bits.
  - Same-cycle set beats clear.
- Out-of-range wch/rch (≥ NUM_CH): treated as no-op; simulation assertion fires.
- Reset (rst=1 at an edge), including mid-operation:
  - All pointers and counts go to 0.
  - overflow, underflow and sticky vectors go to 0.
  - Outputs following reset: empty all 1s, full 0, almost_empty all 1s, almost_full 0 (legal thresholds), used_slots 0, rdata 0.
  - Inputs presented in the reset cycle are ignored.
- Latency: write-to-rdata 1 cycle; pop-to-next-head 1 cycle; status 1 cycle after the causing edge.

Test Plan:
- Reset, then write 0xA0..0xA3 to ch2 → next cycle: used_slots[ch2]=4, empty[2]=0, rdata at rch=2 is 0xA0. Pop 4× → 0xA0,0xA1,0xA2,0xA3 in order, then empty[2]=1 and rdata=0.
- DEPTH=6: fill ch0 with 6 entries → full[0]=1 and almost_full[0]=1 (thresh 4). 7th write → overflow[0] pulses 1 cycle, ovf_sticky[0]=1, data unchanged. clr_err → sticky cleared.
- Full ch1: simultaneous wen/ren on ch1 for 10 cycles → count stays 6, output order preserved across pointer wrap, no overflow.
- Interleave channels (write ch0 and read ch3 in the same cycle, etc.) → no cross-channel corruption; each channel's used_slots is independent.
- Empty ch3 with ren+wen, value 0x55 → underflow[3] pulses, count=1, rdata=0x55 next cycle. flush[3] with concurrent wen → count 0, no overflow flagged.
- Assert rst with 3 channels partially full → all empty=1, used_slots=0, sticky=0 the next cycle; a subsequent write/read works normally.
